// File: rtl/speles_kontrole_pkg.sv
// Shared types and helpers for the number-game round controller.
package speles_kontrole_pkg;

   localparam int NUM_W = 4;

   typedef logic [0:NUM_W-1] num_t;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      GEN        = 3'd1,
      WAIT_GUESS = 3'd2,
      CHECK      = 3'd3,
      RESULT     = 3'd4,
      DONE       = 3'd5
   } state_t;

   // num_2 idles at all-ones so the comparator cannot report a match against the zero target
   localparam num_t NUM_1_IDLE = 4'b0000;
   localparam num_t NUM_2_IDLE = 4'b1111;

   // Bit 0 is the MSB; feedback from the two top bits gives a maximal period of 15
   function automatic num_t lfsr_next(input num_t s);
      return {s[1:NUM_W-1], s[0] ^ s[1]};
   endfunction

endpackage

// File: rtl/speles_kontrole_if.sv
// Player/comparator bundle around the round controller.
interface speles_kontrole_if #(
   parameter int SCORE_W = 4
) ();
   import speles_kontrole_pkg::*;

   logic               start;
   logic               confirm;
   num_t               guess_sw;
   logic               match;
   num_t               num_1;
   num_t               num_2;
   logic [SCORE_W-1:0] score;
   logic [3:0]         round_idx;
   logic               busy;
   logic               result_valid;
   logic               result_win;
   logic               game_over;

   modport master (
      output start, confirm, guess_sw, match,
      input  num_1, num_2, score, round_idx, busy, result_valid, result_win, game_over
   );

   modport slave (
      input  start, confirm, guess_sw, match,
      output num_1, num_2, score, round_idx, busy, result_valid, result_win, game_over
   );

endinterface

// File: rtl/speles_kontrole_generators.sv
// 4-bit target generator: LFSR that steps only when enabled.
module skaitla_generators
   import speles_kontrole_pkg::*;
#(
   parameter num_t SEED = 4'b1001
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output num_t value
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= SEED;
      end else if (en) begin
         value <= lfsr_next(value);
      end
   end

endmodule

// File: rtl/speles_kontrole.sv
// Round controller: generates targets, latches guesses, scores timed rounds
// and sequences a fixed number of rounds per game.
module speles_kontrole
   import speles_kontrole_pkg::*;
#(
   parameter int         ROUNDS         = 8,
   parameter int         TIMEOUT_CYCLES = 1000,
   parameter logic [3:0] LFSR_SEED      = 4'b1001,
   parameter int         SCORE_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   speles_kontrole_if.slave bus
);

   localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [3:0]         LAST_ROUND = 4'(ROUNDS - 1);

   state_t             state;
   state_t             state_nxt;
   num_t               lfsr;
   num_t               num_1;
   num_t               num_2;
   logic [TIMER_W-1:0] timer;
   logic [SCORE_W-1:0] score;
   logic [3:0]         round_idx;
   logic               result_win;
   logic               busy;
   logic               result_valid;
   logic               game_over;
   logic               busy_d;
   logic               result_valid_d;
   logic               game_over_d;
   logic               gen_en;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == SCORE_MAX) ? s : s + 1'b1;
   endfunction

   assign gen_en = (state == GEN);

   skaitla_generators #(
      .SEED (LFSR_SEED)
   ) u_generators (
      .clk   (clk),
      .rst   (rst),
      .en    (gen_en),
      .value (lfsr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A confirm on the timer==0 cycle still counts as a guess
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: if (bus.start) state_nxt = GEN;
         GEN:        state_nxt = WAIT_GUESS;
         WAIT_GUESS: begin
            if (bus.confirm) begin
               state_nxt = CHECK;
            end else if (timer == '0) begin
               state_nxt = RESULT;
            end
         end
         CHECK:      state_nxt = RESULT;
         RESULT:     state_nxt = (round_idx == LAST_ROUND) ? DONE : GEN;
         default:    state_nxt = IDLE;
      endcase
   end

   // Flags are decoded from the upcoming state so they leave a register
   always_comb begin
      busy_d         = 1'b0;
      result_valid_d = 1'b0;
      game_over_d    = 1'b0;
      case (state_nxt)
         GEN, WAIT_GUESS, CHECK: busy_d = 1'b1;
         RESULT: begin
            busy_d         = 1'b1;
            result_valid_d = 1'b1;
         end
         DONE:    game_over_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num_1        <= NUM_1_IDLE;
         num_2        <= NUM_2_IDLE;
         timer        <= '0;
         score        <= '0;
         round_idx    <= '0;
         result_win   <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         busy         <= busy_d;
         result_valid <= result_valid_d;
         game_over    <= game_over_d;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  score     <= '0;
                  round_idx <= '0;
               end
            end
            GEN: begin
               num_1 <= lfsr;
               num_2 <= NUM_2_IDLE;
               timer <= TIMER_LOAD;
            end
            WAIT_GUESS: begin
               timer <= timer - 1'b1;
               if (bus.confirm) begin
                  num_2 <= bus.guess_sw;
               end else if (timer == '0) begin
                  result_win <= 1'b0;
               end
            end
            CHECK: result_win <= bus.match;
            RESULT: begin
               if (result_win) score <= sat_inc(score);
               if (round_idx != LAST_ROUND) round_idx <= round_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.num_1        = num_1;
   assign bus.num_2        = num_2;
   assign bus.score        = score;
   assign bus.round_idx    = round_idx;
   assign bus.busy         = busy;
   assign bus.result_valid = result_valid;
   assign bus.result_win   = result_win;
   assign bus.game_over    = game_over;

endmodule
